// File: rtl/imem_fetch_buffer_if.sv
// Pipeline-side imem port and external memory read bus of imem_fetch_buffer.
interface imem_fetch_buffer_if #(
  parameter int unsigned ADDR_W = 64
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_addr_valid;
  logic [63:0]       imem_data;
  logic              imem_data_valid;
  logic              inv;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [63:0]       mem_rdata;

  modport slave (
    input  imem_addr, imem_addr_valid, inv, mem_ack, mem_rdata,
    output imem_data, imem_data_valid, mem_req, mem_addr
  );

  modport master (
    output imem_addr, imem_addr_valid, inv, mem_ack, mem_rdata,
    input  imem_data, imem_data_valid, mem_req, mem_addr
  );
endinterface

// File: rtl/imem_fetch_buffer.sv
// Direct-mapped 64-bit instruction buffer between the fetch stage and instruction memory.
// Define IMEM_PREFETCH_EN to add a next-doubleword prefetch after each demand fill.
module imem_fetch_buffer #(
  parameter int unsigned IDX_BITS = 3,
  parameter int unsigned ADDR_W   = 64
) (
  input logic                clk,
  input logic                rst,
  imem_fetch_buffer_if.slave bus
);
  localparam int unsigned NENT   = 1 << IDX_BITS;
  localparam int unsigned LINE_W = ADDR_W - 3;
  localparam int unsigned TAG_W  = LINE_W - IDX_BITS;

`ifdef IMEM_PREFETCH_EN
  typedef enum logic [1:0] {IDLE, MISS, RESP, PREFETCH} state_t;
`else
  typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;
`endif

  state_t            state_q, state_d;
  logic [NENT-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [NENT];
  logic [63:0]       data_q [NENT];
  logic [LINE_W-1:0] line_q, line_d;
  logic              abandon_q, abandon_d, abandon_now;
  logic              inv_seen_q, inv_seen_d;
  logic              mem_req_q, mem_req_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              fill_en;

  logic [LINE_W-1:0]   req_line;
  logic [IDX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]    req_tag, fill_tag;
  logic                hit;
  logic                unused_low;

  assign req_line   = bus.imem_addr[ADDR_W-1:3];
  assign req_idx    = req_line[IDX_BITS-1:0];
  assign req_tag    = req_line[LINE_W-1:IDX_BITS];
  assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill_idx   = line_q[IDX_BITS-1:0];
  assign fill_tag   = line_q[LINE_W-1:IDX_BITS];
  assign unused_low = ^bus.imem_addr[2:0];

`ifdef IMEM_PREFETCH_EN
  logic                demand_q, demand_d;
  logic [LINE_W-1:0]   pf_line;
  logic [IDX_BITS-1:0] pf_idx;
  logic                pf_hit;

  // Line arithmetic wraps naturally at the top of the address space.
  assign pf_line = line_q + 1'b1;
  assign pf_idx  = pf_line[IDX_BITS-1:0];
  assign pf_hit  = valid_q[pf_idx] && (tag_q[pf_idx] == pf_line[LINE_W-1:IDX_BITS]);
`endif

  assign bus.mem_req         = mem_req_q;
  assign bus.mem_addr        = {line_q, 3'b000};
  assign bus.imem_data       = rdata_q;
  assign bus.imem_data_valid = rvalid_q;

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    abandon_d   = abandon_q;
    abandon_now = abandon_q;
    inv_seen_d  = inv_seen_q | bus.inv;
    mem_req_d   = mem_req_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    fill_en     = 1'b0;
`ifdef IMEM_PREFETCH_EN
    demand_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.imem_addr_valid) begin
          if (hit) begin
            rvalid_d = 1'b1;
            rdata_d  = data_q[req_idx];
            state_d  = RESP;
          end else begin
            state_d    = MISS;
            line_d     = req_line;
            mem_req_d  = 1'b1;
            abandon_d  = 1'b0;
            inv_seen_d = 1'b0;
          end
        end
      end
      MISS: begin
        // Abandon is sticky: a request that returns after dropping is a new lookup.
        abandon_now = abandon_q | ~bus.imem_addr_valid | (req_line != line_q);
        abandon_d   = abandon_now;
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          fill_en   = ~(inv_seen_q | bus.inv);
          if (abandon_now) begin
            state_d = IDLE;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = bus.mem_rdata;
            state_d  = RESP;
`ifdef IMEM_PREFETCH_EN
            demand_d = 1'b1;
`endif
          end
        end
      end
      RESP: begin
        state_d = IDLE;
`ifdef IMEM_PREFETCH_EN
        if (demand_q && !pf_hit) begin
          state_d    = PREFETCH;
          line_d     = pf_line;
          mem_req_d  = 1'b1;
          inv_seen_d = 1'b0;
        end
`endif
      end
`ifdef IMEM_PREFETCH_EN
      PREFETCH: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          fill_en   = ~(inv_seen_q | bus.inv);
          state_d   = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      line_q     <= '0;
      abandon_q  <= 1'b0;
      inv_seen_q <= 1'b0;
      mem_req_q  <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
`ifdef IMEM_PREFETCH_EN
      demand_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      abandon_q  <= abandon_d;
      inv_seen_q <= inv_seen_d;
      mem_req_q  <= mem_req_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
`ifdef IMEM_PREFETCH_EN
      demand_q   <= demand_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.inv) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_imem_fetch_buffer.sv
// Scoreboard bench for imem_fetch_buffer: expected words and bus addresses are queued by each test.
module tb_imem_fetch_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_fetch_buffer_if #(.ADDR_W(64)) bus ();
  imem_fetch_buffer #(.IDX_BITS(3), .ADDR_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int dv_count = 0;
  int req_cnt  = 0;
  bit mem_en   = 1'b1;
  int mem_lat  = 3;
  logic [63:0] exp_q[$];
  logic [63:0] exp_bus[$];

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h1000) return 64'hDEADBEEF_CAFEF00D;
    return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
  endfunction

  // Memory responder and output monitor; acts on falling edges.
  task automatic env_loop();
    int cnt = 0;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (bus.mem_req) req_cnt++;
      if (!rst && bus.imem_data_valid) begin
        dv_count++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_data_valid: got data %h, required no response", bus.imem_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.imem_data !== e) begin
            n_fail++;
            $display("FAIL imem_data: got %h, required %h", bus.imem_data, e);
          end
        end
      end
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_en && bus.mem_req) begin
        cnt++;
        if (cnt > mem_lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_addr);
          n_checks++;
          if (exp_bus.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_bus_read: got mem_addr %h, required no read", bus.mem_addr);
          end else begin
            e = exp_bus.pop_front();
            if (bus.mem_addr !== e) begin
              n_fail++;
              $display("FAIL mem_addr: got %h, required %h", bus.mem_addr, e);
            end
          end
        end
      end else begin
        cnt = 0;
      end
    end
  endtask

  // Starts at posedge+1; lat = cycles from request cycle to data_valid cycle, -1 on timeout.
  task automatic do_req(input logic [63:0] a, input bit hold, output int lat);
    int cyc = 0;
    lat = -1;
    bus.imem_addr = a;
    bus.imem_addr_valid = 1'b1;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.imem_data_valid) begin
        lat = cyc - 1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!hold) bus.imem_addr_valid = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    repeat (2) @(posedge clk);
    #1;
    while (bus.mem_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_inv();
    bus.inv = 1'b1;
    @(posedge clk); #1;
    bus.inv = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.imem_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b, required 0", bus.imem_data_valid); end
    n_checks++;
    if (bus.imem_data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", bus.imem_data); end
    n_checks++;
    if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b, required 0", bus.mem_req); end
    n_checks++;
    if (bus.mem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h, required 0", bus.mem_addr); end
  endtask

  task automatic test_cold_miss();
    int lat;
    exp_q.push_back(64'hDEADBEEF_CAFEF00D);
    exp_bus.push_back(64'h1000);
`ifdef IMEM_PREFETCH_EN
    exp_bus.push_back(64'h1008);
`endif
    do_req(64'h1000, 1'b0, lat);
    n_checks++;
    if (lat !== mem_lat + 2) begin n_fail++; $display("FAIL cold_miss_latency: got %0d, required %0d", lat, mem_lat + 2); end
    settle();
  endtask

  task automatic test_hit();
    int lat;
    int req0 = req_cnt;
    exp_q.push_back(64'hDEADBEEF_CAFEF00D);
    do_req(64'h1000, 1'b0, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL hit_latency: got %0d, required 1", lat); end
    settle();
    n_checks++;
    if (req_cnt !== req0) begin n_fail++; $display("FAIL hit_no_bus: got %0d mem_req cycles, required 0", req_cnt - req0); end
  endtask

  task automatic test_conflict();
    int lat;
    logic [63:0] addrs [3] = '{64'h1000, 64'h1040, 64'h1000};
    pulse_inv();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mem_word(addrs[i]));
      exp_bus.push_back(addrs[i]);
`ifdef IMEM_PREFETCH_EN
      exp_bus.push_back(addrs[i] + 64'h8);
`endif
      do_req(addrs[i], 1'b0, lat);
      n_checks++;
      if (lat !== mem_lat + 2) begin n_fail++; $display("FAIL conflict_miss_latency[%0d]: got %0d, required %0d", i, lat, mem_lat + 2); end
      settle();
    end
  endtask

  task automatic test_abandon();
    int lat;
    int n = 0;
    int dv0 = dv_count;
    exp_bus.push_back(64'h2000);
    bus.imem_addr = 64'h2004;
    bus.imem_addr_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.imem_addr_valid = 1'b0;
    while (exp_bus.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_bus.size() != 0) begin n_fail++; $display("FAIL abandon_bus_read: got %0d reads pending, required 0", exp_bus.size()); end
    n_checks++;
    if (dv_count != dv0) begin n_fail++; $display("FAIL abandon_no_response: got %0d responses, required 0", dv_count - dv0); end
    exp_q.push_back(mem_word(64'h2000));
    do_req(64'h2000, 1'b0, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL abandon_refill_hit_latency: got %0d, required 1", lat); end
    settle();
  endtask

  task automatic test_inv_mid_miss();
    int lat1, lat2;
    exp_q.push_back(mem_word(64'h3000));
    exp_bus.push_back(64'h3000);
`ifdef IMEM_PREFETCH_EN
    exp_bus.push_back(64'h3008);
`endif
    fork
      do_req(64'h3000, 1'b0, lat1);
      begin
        repeat (2) @(posedge clk);
        #1;
        pulse_inv();
      end
    join
    n_checks++;
    if (lat1 !== mem_lat + 2) begin n_fail++; $display("FAIL inv_miss_latency: got %0d, required %0d", lat1, mem_lat + 2); end
    settle();
    // The inv'd fill was not installed, so the same address goes to memory again.
    exp_q.push_back(mem_word(64'h3000));
    exp_bus.push_back(64'h3000);
    do_req(64'h3000, 1'b0, lat2);
    n_checks++;
    if (lat2 !== mem_lat + 2) begin n_fail++; $display("FAIL inv_rerequest_latency: got %0d, required %0d", lat2, mem_lat + 2); end
    settle();
  endtask

  task automatic test_back_to_back();
    int lat0, lat1, lat2;
    exp_q.push_back(mem_word(64'h6010));
    exp_bus.push_back(64'h6010);
`ifdef IMEM_PREFETCH_EN
    exp_bus.push_back(64'h6018);
`endif
    do_req(64'h6010, 1'b0, lat0);
    n_checks++;
    if (lat0 !== mem_lat + 2) begin n_fail++; $display("FAIL b2b_fill_latency: got %0d, required %0d", lat0, mem_lat + 2); end
    settle();
    exp_q.push_back(mem_word(64'h3000));
    exp_q.push_back(mem_word(64'h6010));
    do_req(64'h3000, 1'b1, lat1);
    do_req(64'h6010, 1'b0, lat2);
    n_checks++;
    if (lat1 !== 1) begin n_fail++; $display("FAIL b2b_first_latency: got %0d, required 1", lat1); end
    n_checks++;
    if (lat2 !== 1) begin n_fail++; $display("FAIL b2b_second_latency: got %0d, required 1", lat2); end
    settle();
  endtask

`ifdef IMEM_PREFETCH_EN
  task automatic test_prefetch();
    int lat;
    exp_q.push_back(mem_word(64'h4000));
    exp_bus.push_back(64'h4000);
    exp_bus.push_back(64'h4008);
    do_req(64'h4000, 1'b0, lat);
    n_checks++;
    if (lat !== mem_lat + 2) begin n_fail++; $display("FAIL pf_demand_latency: got %0d, required %0d", lat, mem_lat + 2); end
    settle();
    exp_q.push_back(mem_word(64'h4008));
    do_req(64'h4008, 1'b0, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL pf_hit_latency: got %0d, required 1", lat); end
    settle();
    exp_q.push_back(mem_word(64'hFFFF_FFFF_FFFF_FFF8));
    exp_bus.push_back(64'hFFFF_FFFF_FFFF_FFF8);
    exp_bus.push_back(64'h0);
    do_req(64'hFFFF_FFFF_FFFF_FFF8, 1'b0, lat);
    n_checks++;
    if (lat !== mem_lat + 2) begin n_fail++; $display("FAIL pf_wrap_demand_latency: got %0d, required %0d", lat, mem_lat + 2); end
    settle();
    exp_q.push_back(mem_word(64'h0));
    do_req(64'h0, 1'b0, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL pf_wrap_hit_latency: got %0d, required 1", lat); end
    settle();
  endtask
`endif

  task automatic test_reset_mid_miss();
    int lat;
    int dv0, req0;
    mem_en = 1'b0;
    bus.imem_addr = 64'h5000;
    bus.imem_addr_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_miss_mem_req: got %b, required 1", bus.mem_req); end
    n_checks++;
    if (bus.mem_addr !== 64'h5000) begin n_fail++; $display("FAIL rst_miss_mem_addr: got %h, required 5000", bus.mem_addr); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.imem_addr_valid = 1'b0;
    n_checks++;
    if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req_drop: got %b, required 0", bus.mem_req); end
    dv0 = dv_count;
    req0 = req_cnt;
    @(negedge clk); #1;
    bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    bus.mem_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (dv_count != dv0) begin n_fail++; $display("FAIL stray_ack_response: got %0d responses, required 0", dv_count - dv0); end
    n_checks++;
    if (req_cnt != req0) begin n_fail++; $display("FAIL stray_ack_mem_req: got %0d mem_req cycles, required 0", req_cnt - req0); end
    mem_en = 1'b1;
    exp_q.push_back(64'hDEADBEEF_CAFEF00D);
    exp_bus.push_back(64'h1000);
`ifdef IMEM_PREFETCH_EN
    exp_bus.push_back(64'h1008);
`endif
    do_req(64'h1000, 1'b0, lat);
    n_checks++;
    if (lat !== mem_lat + 2) begin n_fail++; $display("FAIL post_reset_miss_latency: got %0d, required %0d", lat, mem_lat + 2); end
    settle();
  endtask

  task automatic test_drain();
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL pending_responses: got %0d outstanding, required 0", exp_q.size()); end
    n_checks++;
    if (exp_bus.size() != 0) begin n_fail++; $display("FAIL pending_bus_reads: got %0d outstanding, required 0", exp_bus.size()); end
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_addr = '0;
    bus.imem_addr_valid = 1'b0;
    bus.inv = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    fork
      env_loop();
      begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_abandon();
        test_inv_mid_miss();
        test_back_to_back();
`ifdef IMEM_PREFETCH_EN
        test_prefetch();
`endif
        test_reset_mid_miss();
        test_drain();
      end
      begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish within 1 ms");
        $fatal(1, "bench timeout");
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
